mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Parametrised memory-port controller for the multi-cycle CPU core. Arbitrates between instruction-fetch and data (load/store) requests and sequences each access over the shared memory interface: readM/writeM strobes, address, bidirectional data bus, and the inputReady/ackOutput handshake. Adds a wait-state-tolerant FSM, data-over-fetch priority and a bounded timeout with error reporting, all generalised in data and address width.

## Interface
- WORD_SIZE, 16, data bus and request data width
- ADDR_SIZE, 16, address width
- TIMEOUT, 255, max cycles waiting for a memory handshake; 0 disables the timeout

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch request, held until fetch_ack
- fetch_addr  in  ADDR_SIZE  fetch address
- fetch_ack  out  1  one-cycle pulse, fetch_data valid
- fetch_data  out  WORD_SIZE  fetched word, registered
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- d_ack  out  1  one-cycle pulse, access complete
- d_rdata  out  WORD_SIZE  load data, registered
- err  out  1  high with the ack pulse when the access timed out
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  ADDR_SIZE  memory address
- data  inout  WORD_SIZE  driven only in WRITE, else high-Z
- inputReady  in  1  memory read data valid
- ackOutput  in  1  memory write accepted

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: if d_req, latch d_addr/d_we/d_wdata and go to READ (d_we=0) or WRITE (d_we=1); else if fetch_req, latch fetch_addr and go to READ. Data beats fetch when both are pending. The loser stays pending.
- READ: readM=1, address=latched. On an edge with inputReady=1, capture data into the selected read register and go to RESP.
- WRITE: writeM=1, address=latched, data=latched wdata. On an edge with ackOutput=1, go to RESP.
- RESP: strobes low, bus high-Z. Pulse the ack of the owning client for one cycle, then go to IDLE.
- Timeout: counter clears on entry to READ/WRITE and increments each cycle there. When it reaches TIMEOUT with no handshake, go to RESP with err=1; the read register loads all-ones.
- Latched address, data and direction are frozen for the whole access. Input changes after latching are ignored.
- inputReady is ignored outside READ; ackOutput is ignored outside WRITE.
- If a request drops mid-access, the access still completes and the ack still pulses.

## Timing
- Reset values: readM=0, writeM=0, address=0, data=Z, fetch_ack=0, d_ack=0, err=0, fetch_data=0, d_rdata=0, state IDLE, counter 0.
- Reset asserted mid-access aborts immediately and asynchronously: strobes drop and the bus is released in the same cycle; no ack is issued.
- Minimum latency: request high in cycle n, strobe in n+1, handshake sampled at end of n+1, ack in n+2. Each memory wait cycle adds 1.
- IDLE is not re-entered on the same edge that ends RESP. Back-to-back accesses therefore have a gap of at least one strobe-low cycle.
- The client must drop or change its request in the cycle after ack. A request still high in that cycle starts a new access.
- Handshake and timeout on the same edge: the handshake wins and err=0.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

## Structure
- Shared header, alongside opcodes.v: WORD_SIZE default and the state encodings (IDLE/READ/WRITE/RESP, 2-bit).
- Sub-module bus_timeout_counter (clear, enable, done), parametrised by TIMEOUT. It ties done=0 when TIMEOUT=0.
- All outputs come from registers or state decode only. No combinational path from inputReady/ackOutput to outputs.

## Test plan
- Fetch at 0x0010, memory drives 0xA5C3 with inputReady in the first READ cycle -> readM high 1 cycle, fetch_ack in n+2, fetch_data=0xA5C3, err=0.
- Store 0x1234 to 0x0200, ackOutput delayed 3 cycles -> writeM and data=0x1234 held 4 cycles, d_ack pulse once, bus Z before and after.
- fetch_req and d_req (load) both rise in the same cycle -> load served first, d_ack; fetch begins after RESP, fetch_ack follows.
- TIMEOUT=4, load with no inputReady -> readM high 4 cycles, d_ack with err=1, d_rdata=0xFFFF.
- reset_n asserted during WRITE -> writeM=0 and data=Z immediately; no ack; a fresh fetch after release completes normally.
- WORD_SIZE=32, ADDR_SIZE=24, fetch 0xDEADBEEF -> full-width capture, upper address bits driven correctly.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the CPU memory-port controller: default widths,
// FSM state encoding and access ownership.
package mem_bus_ctrl_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_ADDR_SIZE = 16;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  // Wide enough to hold TIMEOUT itself so the counter can saturate there.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_timeout.sv
// Saturating wait-cycle counter for the memory handshake; done flags the
// last allowed wait cycle. TIMEOUT=0 disables it entirely.
module bus_timeout_counter
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset_n, clear, enable};
    assign done = 1'b0;
  end else begin : g_on
    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && (count != MAX)) begin
        count <= count + CW'(1);
      end
    end

    // The edge ending this cycle is the one on which the count reaches TIMEOUT.
    assign done = enable && (count == LAST);
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-port controller: arbitrates fetch vs data requests and runs each
// access over the shared readM/writeM bus with a bounded handshake wait.
//
// state | meaning
// IDLE  | no access; d_req wins over fetch_req, request fields latched
// READ  | readM high, waiting for inputReady or timeout
// WRITE | writeM high, bus driven, waiting for ackOutput or timeout
// RESP  | strobes low, bus released, one-cycle ack to owner (err if timed out)
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_ack,
  output logic [WORD_SIZE-1:0] fetch_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 err,
  output logic                 readM,
  output logic                 writeM,
  output logic [ADDR_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  state_t                 state;
  state_t                 state_n;
  owner_t                 owner;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   rd_word;
  logic                   in_access;
  logic                   tmo_done;
  logic                   handshake;
  logic                   timeout_hit;

  assign in_access   = (state == READ) || (state == WRITE);
  assign handshake   = ((state == READ) && inputReady) || ((state == WRITE) && ackOutput);
  assign timeout_hit = in_access && tmo_done && !handshake;
  assign rd_word     = inputReady ? data : '1;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_access),
    .enable  (in_access),
    .done    (tmo_done)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (d_req) begin
          state_n = d_we ? WRITE : READ;
        end else if (fetch_req) begin
          state_n = READ;
        end
      end
      READ: begin
        if (inputReady || tmo_done) state_n = RESP;
      end
      WRITE: begin
        if (ackOutput || tmo_done) state_n = RESP;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Request fields are captured only in IDLE so they stay frozen for the access.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      owner      <= OWN_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      fetch_data <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (d_req) begin
          owner   <= OWN_DATA;
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
        end else if (fetch_req) begin
          owner  <= OWN_FETCH;
          addr_q <= fetch_addr;
        end
      end
      if ((state == READ) && (inputReady || tmo_done)) begin
        if (owner == OWN_DATA) begin
          d_rdata <= rd_word;
        end else begin
          fetch_data <= rd_word;
        end
      end
      // Set only on the edge into RESP; RESP itself always clears it.
      err <= timeout_hit;
    end
  end

  assign readM     = (state == READ);
  assign writeM    = (state == WRITE);
  assign address   = addr_q;
  assign data      = (state == WRITE) ? wdata_q : 'z;
  assign fetch_ack = (state == RESP) && (owner == OWN_FETCH);
  assign d_ack     = (state == RESP) && (owner == OWN_DATA);

endmodule
